amux_sel_sequencer: RTL and testbench
=====================================

# amux_sel_sequencer

Digital sequencer that drives the 1.8 V `SEL` input of the 2-input analog multiplexer and schedules the downstream ADC conversion on the multiplexer output. It accepts channel-conversion requests over a valid/ready handshake, or generates them itself in scan mode. It switches `sel`, holds off for a programmable analog settling time, pulses the ADC start, and returns the result, or a timeout error, over a second valid/ready handshake. It sits in the 1.8 V digital domain between the register/CPU side and the analog mux + ADC pair.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16: clocks held after a `sel` change before ADC start; legal range 1..255.
- `TIMEOUT_CYCLES`, default 1024: maximum clocks from `adc_start` to `adc_done`; legal range 2..65535.
- `DATA_W`, default 10: ADC result width.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: reset. One clock; reset is synchronous and active-low.
- `scan_en`, in, 1: when 1 and no request is pending, the block auto-alternates channels.
- `req_valid`, in, 1: conversion request.
- `req_ch`, in, 1: requested channel. 0 selects AIN1; 1 selects AIN2.
- `req_ready`, out, 1: block is idle and can accept a request.
- `sel`, out, 1: registered mux select driven to the analog mux `SEL`.
- `adc_start`, out, 1: single-cycle conversion start pulse.
- `adc_done`, in, 1: conversion-complete strobe from the ADC.
- `adc_data`, in, DATA_W: ADC result. Valid in the cycle `adc_done` is 1.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_ch`, out, 1: channel the response belongs to.
- `rsp_data`, out, DATA_W: captured result. Forced to 0 on error.
- `rsp_err`, out, 1: 1 means the conversion timed out.
- `busy`, out, 1: 1 in any state other than IDLE.

## Operation
- FSM states: IDLE, SETTLE, START, CONV, RESP.
- IDLE, request path:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, the block latches `req_ch` as the current channel.
  - If `req_ch != sel`: `sel <= req_ch`, the settle counter loads `SETTLE_CYCLES-1`, and the FSM goes to SETTLE.
  - If `req_ch == sel`: the FSM goes to START and no settle occurs.
- IDLE, scan path:
  - Applies when `scan_en=1` and `req_valid=0`.
  - The block issues an internal request for `~sel` and behaves exactly as the request path, except that `req_ready` does not handshake.
  - `req_valid` always has priority over scan.
- SETTLE: the counter decrements each cycle. When the counter reaches 0, the FSM goes to START.
- START: `adc_start=1` for this cycle only. The timeout counter clears. The FSM goes to CONV.
- CONV:
  - On `adc_done=1`: `rsp_data <= adc_data`, `rsp_err <= 0`, and the FSM goes to RESP.
  - If `TIMEOUT_CYCLES` cycles of CONV elapse without `adc_done`: `rsp_data <= 0`, `rsp_err <= 1`, and the FSM goes to RESP.
  - `adc_done` is ignored in every state except CONV, including the START cycle.
- RESP:
  - `rsp_valid=1`. `rsp_ch`, `rsp_data` and `rsp_err` are held stable.
  - On `rsp_ready=1` the FSM goes to IDLE. The next request can be accepted in the following cycle.
- `sel` changes only on a request or scan accept in IDLE, and on reset. It never changes during SETTLE, START, CONV or RESP.
- Reset values (`resetn=0` sampled at an edge):
  - State = IDLE.
  - `sel=0`, `adc_start=0`, `rsp_valid=0`, `rsp_ch=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`.
  - `req_ready=0` while `resetn=0`; `req_ready=1` from the first cycle after reset release.
  - Reset mid-operation aborts immediately. Any pending response is discarded, and `sel` returning to 0 is intended.
- All outputs are registered except `req_ready`, which decodes from state and `resetn`.

## Timing
- Accept occurs at edge E0. `sel` shows its new value in cycle 1 (after E0).
- Channel change: SETTLE occupies cycles 1..SETTLE_CYCLES, and `adc_start` is high in cycle SETTLE_CYCLES+1. With the default of 16, that is cycle 17.
- Same channel: `adc_start` is high in cycle 1.
- `adc_done` sampled in cycle k of CONV gives `rsp_valid=1` in cycle k+1.
- Timeout: `rsp_valid` rises exactly TIMEOUT_CYCLES+1 cycles after the `adc_start` cycle.
- Back-to-back throughput: when `rsp_ready` is held at 1, RESP lasts one cycle, then IDLE lasts at least one cycle.

## Test plan
- Channel change with default settle: reset, then request `req_ch=1`; the ADC returns `adc_done` 5 cycles after start with data 0x2A5. Required: `sel`=1 in cycle 1; `adc_start` only in cycle 17; `rsp_valid` with `rsp_ch=1`, `rsp_data=0x2A5`, `rsp_err=0`.
- Same channel: issue a second request with `req_ch=1` immediately after the first. Required: no settle; `adc_start` in cycle 1 after accept; `sel` stays 1 throughout.
- Timeout with `TIMEOUT_CYCLES=8`: the ADC never asserts done. Required: `rsp_valid` exactly 9 cycles after `adc_start`; `rsp_err=1`; `rsp_data=0`.
- Backpressure: hold `rsp_ready=0` for 20 cycles. Required: response fields stable throughout; `req_ready=0` throughout; a request presented during this window is not accepted until the cycle after the `rsp_ready` handshake.
- Scan mode: `scan_en=1` with no requests for 4 conversions. Required: `rsp_ch` sequence 1,0,1,0; each conversion includes a full settle. Then inject `req_valid` with `req_ch=0` while in IDLE: the request wins over scan.
- Reset mid-CONV with `sel=1`: assert `resetn=0` for one edge. Required: all outputs at reset values the next cycle, including `sel=0`; no `rsp_valid`; a late `adc_done` arriving afterwards is ignored.

Source files
------------

// File: rtl/amux_sel_sequencer.sv
// Sequencer for the 2:1 analog mux select line: accepts or generates channel
// requests, waits out analog settling, runs one ADC conversion, returns the result.
module amux_sel_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DATA_W         = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              scan_en,
  input  logic              req_valid,
  input  logic              req_ch,
  output logic              req_ready,
  output logic              sel,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_ch,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_CONV, S_RESP} state_e;

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                adc_start_q, adc_start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_ch_q, rsp_ch_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic [7:0]          settle_q, settle_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                want_ch;

  // A real request always beats the scan generator, which targets the other channel.
  assign want_ch = req_valid ? req_ch : ~sel_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rsp_ch_d   = rsp_ch_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid || scan_en) begin
          if (want_ch != sel_q) begin
            sel_d    = want_ch;
            settle_d = SETTLE_LOAD;
            state_d  = S_SETTLE;
          end else begin
            state_d  = S_START;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == 8'd0) state_d  = S_START;
        else                  settle_d = settle_q - 8'd1;
      end
      S_START: begin
        tmo_d   = 16'd0;
        state_d = S_CONV;
      end
      S_CONV: begin
        if (adc_done) begin
          rsp_data_d = adc_data;
          rsp_err_d  = 1'b0;
          rsp_ch_d   = sel_q;
          state_d    = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_ch_d   = sel_q;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered copies of the next-state decode so they line up with the state.
    adc_start_d = (state_d == S_START);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      adc_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      settle_q    <= 8'd0;
      tmo_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      adc_start_q <= adc_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req_ready = resetn & (state_q == S_IDLE);
  assign sel       = sel_q;
  assign adc_start = adc_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_amux_sel_sequencer.sv
// Directed + randomized bench for amux_sel_sequencer; expected timing for each
// conversion is derived arithmetically from the channel, settle and timeout rules.
module tb_amux_sel_sequencer;
  localparam int S  = 16;
  localparam int T  = 8;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          resetn, scan_en, req_valid, req_ch, req_ready, sel, adc_start, adc_done;
  logic [DW-1:0] adc_data, rsp_data;
  logic          rsp_valid, rsp_ready, rsp_ch, rsp_err, busy;

  int vecs = 0;
  int errs = 0;
  bit m_sel = 1'b0;

  amux_sel_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn), .scan_en(scan_en), .req_valid(req_valid), .req_ch(req_ch),
    .req_ready(req_ready), .sel(sel), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_adc_start"}, 32'(adc_start), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_ch"}, 32'(rsp_ch), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One conversion from an IDLE cycle back to the following IDLE cycle.
  // dly = CONV cycle (1-based, counted after adc_start) holding adc_done; outside 1..T means no done.
  task automatic conv(input bit use_req, input bit use_scan, input bit ch, input int dly,
                      input logic [DW-1:0] data, input int hold, input int abort);
    bit   exp_ch, settle, done_ok;
    int   start_cyc, resp_off;
    logic [DW-1:0] exp_data;
    exp_ch    = use_req ? ch : ~m_sel;
    settle    = (exp_ch != m_sel);
    start_cyc = settle ? S + 1 : 1;
    done_ok   = (dly >= 1) && (dly <= T);
    resp_off  = done_ok ? dly + 1 : T + 1;
    exp_data  = done_ok ? data : '0;

    chk("idle_req_ready", 32'(req_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    req_valid = use_req; req_ch = ch; scan_en = use_scan; rsp_ready = 1'b0;
    adc_done = 1'($urandom_range(0, 1));
    tick();
    req_valid = 1'b0; scan_en = 1'b0;
    m_sel = exp_ch;

    for (int n = 1; n <= start_cyc; n++) begin
      chk("pre_sel", 32'(sel), 32'(exp_ch));
      chk("pre_adc_start", 32'(adc_start), 32'(n == start_cyc));
      chk("pre_busy", 32'(busy), 1);
      chk("pre_req_ready", 32'(req_ready), 0);
      adc_done = 1'($urandom_range(0, 1));
      adc_data = DW'($urandom);
      tick();
    end

    for (int m = 1; m < resp_off; m++) begin
      if (abort > 0 && m == abort) begin
        adc_done = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_req_ready_low", 32'(req_ready), 0);
        tick();
        resetn = 1'b1;
        chk_reset("rst_mid_conv");
        m_sel = 1'b0;
        #1;
        chk("rst_req_ready_high", 32'(req_ready), 1);
        for (int j = 0; j < 3; j++) begin
          adc_done = 1'b1;
          adc_data = DW'($urandom);
          tick();
          chk("late_done_rsp_valid", 32'(rsp_valid), 0);
          chk("late_done_busy", 32'(busy), 0);
          chk("late_done_sel", 32'(sel), 0);
        end
        adc_done = 1'b0;
        return;
      end
      chk("conv_rsp_valid", 32'(rsp_valid), 0);
      chk("conv_adc_start", 32'(adc_start), 0);
      chk("conv_sel", 32'(sel), 32'(exp_ch));
      adc_done = (m == dly);
      adc_data = (m == dly) ? data : DW'($urandom);
      tick();
    end

    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_ch", 32'(rsp_ch), 32'(exp_ch));
      chk("rsp_data", 32'(rsp_data), 32'(exp_data));
      chk("rsp_err", 32'(rsp_err), 32'(!done_ok));
      chk("rsp_req_ready", 32'(req_ready), 0);
      chk("rsp_sel", 32'(sel), 32'(exp_ch));
      // A competing request during backpressure must not be taken.
      req_valid = (hold > 0);
      req_ch    = ~exp_ch;
      rsp_ready = (i == hold);
      adc_done  = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0; adc_done = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_sel", 32'(sel), 32'(exp_ch));
  endtask

  initial begin
    resetn = 1'b0; scan_en = 1'b0; req_valid = 1'b0; req_ch = 1'b0;
    adc_done = 1'b0; adc_data = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("reset_req_ready", 32'(req_ready), 0);
    chk_reset("reset");
    resetn = 1'b1;
    #1;
    chk("release_req_ready", 32'(req_ready), 1);

    // Channel change with full settle, done 5 cycles after start.
    conv(1, 0, 1'b1, 5, 10'h2A5, 0, 0);
    // Same channel immediately after: no settle.
    conv(1, 0, 1'b1, 3, DW'($urandom), 0, 0);
    // Timeout: ADC never answers.
    conv(1, 0, 1'b1, 0, DW'($urandom), 0, 0);
    // Done on the very last allowed CONV cycle still wins over timeout.
    conv(1, 0, 1'b1, T, DW'($urandom), 0, 0);
    // Backpressure for 20 cycles with a competing request, and a switch back to channel 0.
    conv(1, 0, 1'b0, 2, DW'($urandom), 20, 0);
    // Scan mode: four conversions alternating 1,0,1,0.
    for (int i = 0; i < 4; i++) conv(0, 1, 1'b0, 1 + i, DW'($urandom), 0, 0);
    // Request wins over scan (scan would target channel 1).
    conv(1, 1, 1'b0, 4, DW'($urandom), 0, 0);
    // Reset in the middle of CONV with sel=1.
    conv(1, 0, 1'b1, 6, DW'($urandom), 0, 3);

    for (int i = 0; i < 30; i++) begin
      int idle_cyc;
      idle_cyc = $urandom_range(0, 2);
      for (int j = 0; j < idle_cyc; j++) begin
        adc_done = 1'($urandom_range(0, 1));
        tick();
        chk("rand_idle_busy", 32'(busy), 0);
        chk("rand_idle_adc_start", 32'(adc_start), 0);
      end
      adc_done = 1'b0;
      conv(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
           $urandom_range(0, T + 2), DW'($urandom), $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
